seg7_pattern_decoder: RTL and testbench

//  Reader end of the 7-segment display interface: samples an active-low 7-seg bus
//  (seg_in[0]=a .. seg_in[6]=g) and decodes it back to a hex nibble.

---
 rtl/seg7_pattern_decoder_if.sv | 62 ++++++
 rtl/seg7_pattern_decoder.sv | 222 ++++++++++++++++++++++
 tb/tb_seg7_pattern_decoder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_pattern_decoder_if.sv
// -----------------------------------------------------------------------------
// seg7_pattern_decoder_if
//   Bundles the 7-segment sense bus and the decoded results of
//   seg7_pattern_decoder.
//
//   Signals
//     seg_in       7      active-low segment bus, bit0=a .. bit6=g
//     value_out    4      last accepted valid hex digit
//     valid        1      value_out reflects a currently displayed digit
//     invalid_pat  1      last accepted pattern is neither digit nor blank
//     step_up      1      1-cycle pulse, digit == previous + 1 (mod 16)
//     step_down    1      1-cycle pulse, digit == previous - 1 (mod 16)
//     step_err     1      1-cycle pulse, any other digit-to-digit change
//     change_cnt   CNT_W  saturating count of accepted pattern changes
//     state_dbg    2      decoder FSM state (0=EMPTY, 1=LOCKED, 2=FAULT)
//
//   Modports
//     master : the side that drives the display bus and observes the results
//     slave  : the decoder itself
//
//   Handshake: there is no valid/ready pair. seg_in is a free-running level
//   bus sampled on every clock; all result signals are registered levels or
//   single-cycle pulses that are only meaningful when sampled after the
//   rising clock edge on which they change.
// -----------------------------------------------------------------------------
interface seg7_pattern_decoder_if #(
   parameter int CNT_W = 8
);
   logic [6:0]       seg_in;
   logic [3:0]       value_out;
   logic             valid;
   logic             invalid_pat;
   logic             step_up;
   logic             step_down;
   logic             step_err;
   logic [CNT_W-1:0] change_cnt;
   logic [1:0]       state_dbg;

   modport master (
      output seg_in,
      input  value_out,
      input  valid,
      input  invalid_pat,
      input  step_up,
      input  step_down,
      input  step_err,
      input  change_cnt,
      input  state_dbg
   );

   modport slave (
      input  seg_in,
      output value_out,
      output valid,
      output invalid_pat,
      output step_up,
      output step_down,
      output step_err,
      output change_cnt,
      output state_dbg
   );
endinterface

// File: rtl/seg7_pattern_decoder.sv
// -----------------------------------------------------------------------------
// seg7_pattern_decoder
//   Reader end of a 7-segment display link. Samples an active-low segment bus,
//   rejects patterns that are not held for STABLE_CYCLES consecutive samples,
//   decodes accepted patterns back to a hex nibble, counts accepted changes
//   and classifies digit-to-digit transitions as +1 / -1 / other (mod 16).
//
//   Parameters
//     STABLE_CYCLES  consecutive identical samples needed to accept (>=1)
//     CNT_W          width of change_cnt (must match the interface CNT_W)
//
//   Ports
//     clk    in   single clock, all state on posedge
//     reset  in   synchronous, active-high
//     bus    slave modport of seg7_pattern_decoder_if (see that file)
//
//   Configuration macro
//     SEG7_DEC_STEPCHK_EN  defined: step_up/step_down/step_err are generated.
//                          undefined: step_* are tied low and the comparison
//                          logic is absent. Decode, valid, invalid_pat and
//                          change_cnt behave identically in both builds.
//
//   Timing: a new pattern first sampled on edge k and held steady updates the
//   outputs on edge k+STABLE_CYCLES+1.
// -----------------------------------------------------------------------------
module seg7_pattern_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   seg7_pattern_decoder_if.slave  bus
);

   // Stability counter must be able to hold the value STABLE_CYCLES.
   localparam int SW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);

   localparam logic [6:0] PAT_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_LOCKED = 2'd1,
      ST_FAULT  = 2'd2
   } state_e;

   // Returns {is_digit, digit}.
   function automatic logic [4:0] decode(input logic [6:0] pat);
      logic [4:0] r;
      case (pat)
         7'h40:   r = 5'h10;
         7'h79:   r = 5'h11;
         7'h24:   r = 5'h12;
         7'h30:   r = 5'h13;
         7'h19:   r = 5'h14;
         7'h12:   r = 5'h15;
         7'h02:   r = 5'h16;
         7'h78:   r = 5'h17;
         7'h00:   r = 5'h18;
         7'h10:   r = 5'h19;
         7'h08:   r = 5'h1A;
         7'h03:   r = 5'h1B;
         7'h46:   r = 5'h1C;
         7'h21:   r = 5'h1D;
         7'h06:   r = 5'h1E;
         7'h0E:   r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e           state;
   logic [6:0]       seg_q;
   logic [SW-1:0]    stab_cnt;
   logic             taken;
   logic [6:0]       acc_pat;
   logic [3:0]       value_q;
   logic             valid_q;
   logic             invalid_q;
   logic [CNT_W-1:0] change_cnt_q;
`ifdef SEG7_DEC_STEPCHK_EN
   logic             step_up_q;
   logic             step_down_q;
   logic             step_err_q;
`endif

   // ---------------------------------------------------------------------------
   // Sampling / acceptance
   // ---------------------------------------------------------------------------
   logic          seg_same;
   logic [SW-1:0] stab_next;
   logic          accept;
   logic          change_ev;
   logic [4:0]    dec;
   logic          is_digit;
   logic [3:0]    digit;
   logic          is_blank;

   always_comb begin
      seg_same  = (bus.seg_in == seg_q);
      stab_next = '0;
      if (seg_same) begin
         stab_next = (stab_cnt == STAB_MAX) ? STAB_MAX : stab_cnt + 1'b1;
      end
      // taken blocks a second accept of the same steady run.
      accept    = (stab_cnt == STAB_MAX) && !taken;
      // Re-accepting the pattern already on record (e.g. after a short
      // glitch) is not a change and must stay invisible.
      change_ev = accept && (seg_q != acc_pat);
      dec       = decode(seg_q);
      is_digit  = dec[4];
      digit     = dec[3:0];
      is_blank  = (seg_q == PAT_BLANK);
   end

`ifdef SEG7_DEC_STEPCHK_EN
   // value_q holds the previous digit while LOCKED; 4-bit arithmetic gives the
   // F->0 and 0->F wraps for free.
   logic [3:0] prev_plus;
   logic [3:0] prev_minus;

   always_comb begin
      prev_plus  = value_q + 4'd1;
      prev_minus = value_q - 4'd1;
   end
`endif

   // ---------------------------------------------------------------------------
   // Single sequential block: sampler, acceptance and FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_EMPTY;
         seg_q        <= PAT_BLANK;
         stab_cnt     <= '0;
         taken        <= 1'b0;
         acc_pat      <= PAT_BLANK;
         value_q      <= 4'd0;
         valid_q      <= 1'b0;
         invalid_q    <= 1'b0;
         change_cnt_q <= '0;
`ifdef SEG7_DEC_STEPCHK_EN
         step_up_q    <= 1'b0;
         step_down_q  <= 1'b0;
         step_err_q   <= 1'b0;
`endif
      end else begin
         seg_q    <= bus.seg_in;
         stab_cnt <= stab_next;

         // A changed sample restarts the run, so it must also re-arm accept
         // even if this same edge is accepting the old run.
         if (!seg_same) begin
            taken <= 1'b0;
         end else if (accept) begin
            taken <= 1'b1;
         end

`ifdef SEG7_DEC_STEPCHK_EN
         step_up_q   <= 1'b0;
         step_down_q <= 1'b0;
         step_err_q  <= 1'b0;
`endif

         if (change_ev) begin
            acc_pat <= seg_q;
            if (change_cnt_q != {CNT_W{1'b1}}) begin
               change_cnt_q <= change_cnt_q + 1'b1;
            end

            if (is_digit) begin
`ifdef SEG7_DEC_STEPCHK_EN
               if (state == ST_LOCKED) begin
                  // +1 is checked first; for 4 bits +1 and -1 never coincide.
                  if (digit == prev_plus) begin
                     step_up_q <= 1'b1;
                  end else if (digit == prev_minus) begin
                     step_down_q <= 1'b1;
                  end else begin
                     step_err_q <= 1'b1;
                  end
               end
`endif
               value_q   <= digit;
               valid_q   <= 1'b1;
               invalid_q <= 1'b0;
               state     <= ST_LOCKED;
            end else if (is_blank) begin
               valid_q   <= 1'b0;
               invalid_q <= 1'b0;
               state     <= ST_EMPTY;
            end else begin
               valid_q   <= 1'b0;
               invalid_q <= 1'b1;
               state     <= ST_FAULT;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.value_out   = value_q;
   assign bus.valid       = valid_q;
   assign bus.invalid_pat = invalid_q;
   assign bus.change_cnt  = change_cnt_q;
   assign bus.state_dbg   = state;
`ifdef SEG7_DEC_STEPCHK_EN
   assign bus.step_up     = step_up_q;
   assign bus.step_down   = step_down_q;
   assign bus.step_err    = step_err_q;
`else
   assign bus.step_up     = 1'b0;
   assign bus.step_down   = 1'b0;
   assign bus.step_err    = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_pattern_decoder
//   Table of hand-derived vectors, a few hand-written multi-cycle sequences
//   (latency, full up-count sweep, reset during stabilisation, saturation) and
//   a randomized run compared every cycle against a run-length based model.
// -----------------------------------------------------------------------------
module tb_seg7_pattern_decoder;
   localparam int STABLE = 4;
   localparam int CNT_W  = 8;
`ifdef SEG7_DEC_STEPCHK_EN
   localparam int SC = 1;
`else
   localparam int SC = 0;
`endif

   // ---------------------------------------------------------------- clock/reset
   logic clk;
   logic reset;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   seg7_pattern_decoder_if #(.CNT_W(CNT_W)) bus ();

   seg7_pattern_decoder #(
      .STABLE_CYCLES(STABLE),
      .CNT_W        (CNT_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   // ---------------------------------------------------------------- scoreboard
   int checks = 0;
   int errors = 0;

   logic [6:0] codes [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   // Works on runs of identical samples: a run becomes visible the edge after
   // it has reached STABLE+1 identical samples. A reset edge counts as one
   // blank sample that starts a fresh run.
   logic [6:0] m_run_pat;
   int         m_run_len;
   logic [6:0] m_acc;
   logic [3:0] m_value;
   logic       m_valid;
   logic       m_inv;
   logic       m_up, m_dn, m_err;
   int         m_cnt;

   task automatic model_apply(input logic [6:0] p);
      int d;
      d = -1;
      m_acc = p;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      for (int i = 0; i < 16; i++) if (codes[i] == p) d = i;
      if (d >= 0) begin
         if (m_valid && SC == 1) begin
            case ((d - int'(m_value)) & 15)
               1:       m_up  = 1'b1;
               15:      m_dn  = 1'b1;
               default: m_err = 1'b1;
            endcase
         end
         m_value = 4'(d);
         m_valid = 1'b1;
         m_inv   = 1'b0;
      end else if (p == 7'h7F) begin
         m_valid = 1'b0;
         m_inv   = 1'b0;
      end else begin
         m_valid = 1'b0;
         m_inv   = 1'b1;
      end
   endtask

   task automatic model_edge(input logic r, input logic [6:0] x);
      m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0;
      if (r) begin
         m_run_pat = 7'h7F; m_run_len = 1; m_acc = 7'h7F;
         m_value = 4'd0; m_valid = 1'b0; m_inv = 1'b0; m_cnt = 0;
      end else begin
         if (m_run_len == STABLE + 1 && m_run_pat != m_acc) model_apply(m_run_pat);
         if (x == m_run_pat) begin
            if (m_run_len < STABLE + 2) m_run_len++;
         end else begin
            m_run_pat = x;
            m_run_len = 1;
         end
      end
   endtask

   // ---------------------------------------------------------------- driver
   // One clock: drive on the falling edge, compare 1 time unit after the
   // rising edge against the model.
   task automatic step_cycle(input logic r, input logic [6:0] x);
      @(negedge clk);
      reset      = r;
      bus.seg_in = x;
      model_edge(r, x);
      @(posedge clk);
      #1;
      check("m_value", 32'(bus.value_out),   32'(m_value));
      check("m_valid", 32'(bus.valid),       32'(m_valid));
      check("m_inv",   32'(bus.invalid_pat), 32'(m_inv));
      check("m_up",    32'(bus.step_up),     32'(m_up));
      check("m_dn",    32'(bus.step_down),   32'(m_dn));
      check("m_err",   32'(bus.step_err),    32'(m_err));
      check("m_cnt",   32'(bus.change_cnt),  32'(m_cnt));
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic [6:0] seg;
      int         hold;
      logic [3:0] value;
      logic       valid;
      logic       inv;
      int         cnt;
      int         up;
      int         dn;
      int         err;
   } vec_t;

   vec_t tbl [12];

   int up_seen, dn_seen, err_seen;

   task automatic clear_seen();
      up_seen = 0; dn_seen = 0; err_seen = 0;
   endtask

   task automatic note_pulses();
      up_seen  += int'(bus.step_up);
      dn_seen  += int'(bus.step_down);
      err_seen += int'(bus.step_err);
   endtask

   initial begin
      logic [6:0] x;
      logic [6:0] last_x;
      int         hold;
      int         kind;

      codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

      //          seg    hold val  vld  inv  cnt up    dn    err
      tbl[0]  = '{7'h40, 8, 4'h0, 1'b1, 1'b0, 1,  0,    0,    0};
      tbl[1]  = '{7'h79, 8, 4'h1, 1'b1, 1'b0, 2,  SC,   0,    0};
      tbl[2]  = '{7'h24, 8, 4'h2, 1'b1, 1'b0, 3,  SC,   0,    0};
      tbl[3]  = '{7'h7F, 8, 4'h2, 1'b0, 1'b0, 4,  0,    0,    0};
      tbl[4]  = '{7'h55, 8, 4'h2, 1'b0, 1'b1, 5,  0,    0,    0};
      tbl[5]  = '{7'h30, 8, 4'h3, 1'b1, 1'b0, 6,  0,    0,    0};
      tbl[6]  = '{7'h02, 3, 4'h3, 1'b1, 1'b0, 6,  0,    0,    0};
      tbl[7]  = '{7'h30, 8, 4'h3, 1'b1, 1'b0, 6,  0,    0,    0};
      tbl[8]  = '{7'h78, 8, 4'h7, 1'b1, 1'b0, 7,  0,    0,    SC};
      tbl[9]  = '{7'h02, 8, 4'h6, 1'b1, 1'b0, 8,  0,    SC,   0};
      tbl[10] = '{7'h0E, 8, 4'hF, 1'b1, 1'b0, 9,  0,    0,    SC};
      tbl[11] = '{7'h40, 8, 4'h0, 1'b1, 1'b0, 10, SC,   0,    0};

      reset      = 1'b1;
      bus.seg_in = 7'h7F;

      // ---- reset state
      step_cycle(1'b1, 7'h7F);
      check("rst_value", 32'(bus.value_out),   32'd0);
      check("rst_valid", 32'(bus.valid),       32'd0);
      check("rst_inv",   32'(bus.invalid_pat), 32'd0);
      check("rst_cnt",   32'(bus.change_cnt),  32'd0);
      check("rst_steps", 32'({bus.step_up, bus.step_down, bus.step_err}), 32'd0);

      // ---- latency: digit 0 sampled from edge 1, outputs at edge 6
      for (int e = 1; e <= 5; e++) step_cycle(1'b0, 7'h40);
      check("lat_valid_e5", 32'(bus.valid), 32'd0);
      step_cycle(1'b0, 7'h40);
      check("lat_valid_e6", 32'(bus.valid),      32'd1);
      check("lat_value_e6", 32'(bus.value_out),  32'd0);
      check("lat_cnt_e6",   32'(bus.change_cnt), 32'd1);
      check("lat_steps_e6", 32'({bus.step_up, bus.step_down, bus.step_err}), 32'd0);

      // ---- reset while a new digit (9) is at stab_cnt 3
      for (int e = 1; e <= 4; e++) step_cycle(1'b0, codes[9]);
      step_cycle(1'b1, codes[9]);
      check("midrst_valid", 32'(bus.valid),      32'd0);
      check("midrst_value", 32'(bus.value_out),  32'd0);
      check("midrst_cnt",   32'(bus.change_cnt), 32'd0);
      for (int e = 1; e <= 5; e++) step_cycle(1'b0, codes[9]);
      check("midrst_valid_e5", 32'(bus.valid), 32'd0);
      step_cycle(1'b0, codes[9]);
      check("midrst_valid_e6", 32'(bus.valid),      32'd1);
      check("midrst_value_e6", 32'(bus.value_out),  32'd9);
      check("midrst_cnt_e6",   32'(bus.change_cnt), 32'd1);

      // ---- table vectors
      step_cycle(1'b1, 7'h7F);
      foreach (tbl[i]) begin
         clear_seen();
         for (int c = 0; c < tbl[i].hold; c++) begin
            step_cycle(1'b0, tbl[i].seg);
            note_pulses();
         end
         check($sformatf("tbl%0d_value", i), 32'(bus.value_out),   32'(tbl[i].value));
         check($sformatf("tbl%0d_valid", i), 32'(bus.valid),       32'(tbl[i].valid));
         check($sformatf("tbl%0d_inv", i),   32'(bus.invalid_pat), 32'(tbl[i].inv));
         check($sformatf("tbl%0d_cnt", i),   32'(bus.change_cnt),  32'(tbl[i].cnt));
         check($sformatf("tbl%0d_up", i),    32'(up_seen),         32'(tbl[i].up));
         check($sformatf("tbl%0d_dn", i),    32'(dn_seen),         32'(tbl[i].dn));
         check($sformatf("tbl%0d_err", i),   32'(err_seen),        32'(tbl[i].err));
      end

      // ---- full up-count sweep 0..F,0
      step_cycle(1'b1, 7'h7F);
      clear_seen();
      for (int d = 0; d <= 16; d++) begin
         for (int c = 0; c < 8; c++) begin
            step_cycle(1'b0, codes[d % 16]);
            note_pulses();
         end
      end
      check("sweep_up",    32'(up_seen),            32'(16 * SC));
      check("sweep_dn",    32'(dn_seen),            32'd0);
      check("sweep_err",   32'(err_seen),           32'd0);
      check("sweep_cnt",   32'(bus.change_cnt),     32'd17);
      check("sweep_value", 32'(bus.value_out),      32'd0);

      // ---- change counter saturation
      step_cycle(1'b1, 7'h7F);
      for (int n = 0; n < 260; n++) begin
         for (int c = 0; c < 6; c++) step_cycle(1'b0, codes[n % 2]);
      end
      check("sat_cnt",   32'(bus.change_cnt), 32'((1 << CNT_W) - 1));
      check("sat_valid", 32'(bus.valid),      32'd1);

      // ---- randomized run against the model
      step_cycle(1'b1, 7'h7F);
      last_x = 7'h7F;
      for (int s = 0; s < 400; s++) begin
         if ($urandom_range(0, 39) == 0) step_cycle(1'b1, last_x);
         kind = int'($urandom_range(0, 9));
         case (kind)
            0, 1:    x = codes[(int'(m_value) + 1) % 16];
            2:       x = codes[(int'(m_value) + 15) % 16];
            3, 4, 5: x = codes[$urandom_range(0, 15)];
            6:       x = 7'h7F;
            7:       x = 7'($urandom_range(0, 127));
            default: x = last_x;
         endcase
         hold = int'($urandom_range(1, 8));
         for (int c = 0; c < hold; c++) step_cycle(1'b0, x);
         last_x = x;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
